clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Timekeeping core of the digital clock, sitting directly upstream of the hourly chime.
- Advances hour/minute/second once per clk_1Hz edge and supports synchronous preset (load) and manual adjust pulses.
- Emits 6-bit hour/minute/second buses in the format the chime consumes, plus minute/hour/day rollover strobes for downstream consumers.

Parameters:
HOUR_MODE, 24, hour format: 24 (hours 0..23) or 12 (hours 1..12 with pm flag); any other value is illegal.

Ports:
clk_1Hz  in  1  1 Hz system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
run_en  in  1  1 = advance time each cycle, 0 = hold (load/adjust still act)
load  in  1  synchronous preset request, sampled each cycle
load_hour  in  6  preset hour
load_minute  in  6  preset minute
load_second  in  6  preset second
load_pm  in  1  preset pm flag; ignored when HOUR_MODE=24
adj_min  in  1  one-cycle pulse: increment minute
adj_hour  in  1  one-cycle pulse: increment hour
hour  out  6  current hour (binary)
minute  out  6  current minute 0..59
second  out  6  current second 0..59
pm  out  1  pm flag; constant 0 when HOUR_MODE=24
load_err  out  1  one-cycle pulse: rejected preset
min_tick  out  1  one-cycle pulse: second wrapped 59->0
hour_tick  out  1  one-cycle pulse: minute and second both wrapped
day_tick  out  1  one-cycle pulse: day rollover

Behaviour:
- Reset (async assert, sync release): second=0, minute=0, pm=0, all strobes=0, load_err=0. hour=0 for HOUR_MODE=24; hour=12 for HOUR_MODE=12 (12:00:00 am).
- All outputs are registered. Each cycle applies exactly one action class, chosen by priority: load > adjust > count > hold.
- Load:
  - Range check: load_second<=59, load_minute<=59, and hour in 0..23 (24h) or 1..12 (12h).
  - Valid: outputs take the preset values next edge (pm=load_pm in 12h mode).
  - Invalid: state is unchanged, and load_err=1 for exactly one cycle.
  - No ticks fire on any load.
- Adjust (no load this cycle):
  - adj_min: minute=(minute+1) mod 60 with no carry into hour; second cleared to 0.
  - adj_hour: 24h mode gives hour=(hour+1) mod 24. 12h mode sequence is 11->12 with pm toggled, then 12->1, otherwise hour+1.
  - Both pulses in the same cycle apply both increments independently.
  - Adjust never fires ticks and works regardless of run_en.
- Count (run_en=1, no load, no adjust): second+1 each cycle.
  - 59->0 carries into minute and sets min_tick.
  - minute 59->0 carries into hour and sets hour_tick.
  - Hour wraps per the adj_hour rule.
  - day_tick fires on 23:59:59->00:00:00 (24h) or 11:59:59 pm->12:00:00 am (12h).
  - Strobes are registered and high in the same cycle the wrapped value appears on the outputs (for example, outputs read 01:00:00 while min_tick=1 and hour_tick=1).
- Hold (run_en=0, no load, no adjust): all state frozen, strobes 0.
- Reset asserted mid-count or during load overrides everything immediately. A pending load, adjust or strobe is lost.
- Values 60..63 are unreachable; the internal state never leaves its legal range.

Decomposition:
- Package clock_time_pkg holds:
  - TIME_W=6
  - SEC_MAX=59, MIN_MAX=59
  - HOUR24_MAX=23, HOUR12_MIN=1, HOUR12_MAX=12
  - range-check functions, shared with the chime and the display decoder
- One sub-module, mod_counter: parameterised modulus wrap counter with inc, clear, load, value, and a wrap output (combinational carry). It is instantiated for seconds and minutes; hour/pm logic stays in the top level.

Test Plan:
- HOUR_MODE=24, reset then run 61 cycles -> reads 00:01:01; min_tick high only at the 00:01:00 cycle; load_err never asserts.
- Load 23:59:58 (24h), run 2 cycles -> 23:59:59, then 00:00:00 with min_tick=hour_tick=day_tick=1 for that single cycle.
- HOUR_MODE=12, load 11:59:59 pm=0, run 1 -> 12:00:00 pm=1, hour_tick=1, day_tick=0. Load 11:59:59 pm=1, run 1 -> 12:00:00 pm=0, day_tick=1.
- Load 24:00:00 (24h) or 00:10:00 (12h) or minute=60 -> state unchanged, load_err high exactly one cycle.
- run_en=0 at 08:38:15, pulse adj_min and adj_hour together -> 09:39:00; 59 more adj_min pulses wrap minute to 38 with hour still 9 and no ticks.
- Assert reset asynchronously mid-cycle while load=1 and run_en=1 -> outputs immediately 00:00:00 (24h) or 12:00:00 am (12h), strobes 0.

Source files
------------

// File: rtl/clock_time_pkg.sv
// Shared time-of-day constants and range checks for the clock, chime and display.
package clock_time_pkg;

  localparam int unsigned TIME_W     = 6;
  localparam int unsigned SEC_MAX    = 59;
  localparam int unsigned MIN_MAX    = 59;
  localparam int unsigned HOUR24_MAX = 23;
  localparam int unsigned HOUR12_MIN = 1;
  localparam int unsigned HOUR12_MAX = 12;

  function automatic logic second_valid(input logic [TIME_W-1:0] v);
    return v <= TIME_W'(SEC_MAX);
  endfunction

  function automatic logic minute_valid(input logic [TIME_W-1:0] v);
    return v <= TIME_W'(MIN_MAX);
  endfunction

  // mode is the hour format: 12 selects 1..12, anything else is treated as 24h.
  function automatic logic hour_valid(input logic [TIME_W-1:0] v, input int mode);
    if (mode == 12) begin
      return (v >= TIME_W'(HOUR12_MIN)) && (v <= TIME_W'(HOUR12_MAX));
    end
    return v <= TIME_W'(HOUR24_MAX);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulus wrap counter: counts 0..MAX with load > clear > inc priority.
// wrap is a combinational carry, high when inc is requested at MAX.
module mod_counter #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic at_max;

  assign at_max = (value == W'(MAX));
  assign wrap   = inc && at_max;

  // Counter state update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping core: hour/minute/second with preset, manual adjust and rollover strobes.
// Each cycle applies one action class: load > adjust > count > hold.
module clock_time_counter
  import clock_time_pkg::*;
#(
  parameter int HOUR_MODE = 24
) (
  input  logic              clk_1Hz,
  input  logic              reset,
  input  logic              run_en,
  input  logic              load,
  input  logic [TIME_W-1:0] load_hour,
  input  logic [TIME_W-1:0] load_minute,
  input  logic [TIME_W-1:0] load_second,
  input  logic              load_pm,
  input  logic              adj_min,
  input  logic              adj_hour,
  output logic [TIME_W-1:0] hour,
  output logic [TIME_W-1:0] minute,
  output logic [TIME_W-1:0] second,
  output logic              pm,
  output logic              load_err,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              day_tick
);

  localparam logic IS12 = (HOUR_MODE == 12);
  localparam logic [TIME_W-1:0] HOUR_RST = IS12 ? TIME_W'(HOUR12_MAX) : '0;

  logic              load_ok, do_load, do_adj, do_count;
  logic              sec_wrap, min_wrap, min_carry, hour_inc, day_wrap;
  logic [TIME_W-1:0] hour_q, hour_d;
  logic              pm_q, pm_d;

  assign load_ok  = second_valid(load_second) && minute_valid(load_minute) &&
                    hour_valid(load_hour, HOUR_MODE);
  assign do_load  = load && load_ok;
  assign do_adj   = !load && (adj_min || adj_hour);
  assign do_count = !load && !do_adj && run_en;

  mod_counter #(
    .W   (TIME_W),
    .MAX (SEC_MAX)
  ) u_sec (
    .clk        (clk_1Hz),
    .reset      (reset),
    .inc        (do_count),
    .clear      (do_adj && adj_min),
    .load       (do_load),
    .load_value (load_second),
    .value      (second),
    .wrap       (sec_wrap)
  );

  // Minute wrap on a manual adjust must not carry, so only the count carry is used.
  mod_counter #(
    .W   (TIME_W),
    .MAX (MIN_MAX)
  ) u_min (
    .clk        (clk_1Hz),
    .reset      (reset),
    .inc        ((do_adj && adj_min) || sec_wrap),
    .clear      (1'b0),
    .load       (do_load),
    .load_value (load_minute),
    .value      (minute),
    .wrap       (min_wrap)
  );

  assign min_carry = sec_wrap && min_wrap;
  assign hour_inc  = (do_adj && adj_hour) || min_carry;
  assign day_wrap  = min_carry &&
                     (IS12 ? (hour_q == TIME_W'(HOUR12_MAX - 1) && pm_q)
                           : (hour_q == TIME_W'(HOUR24_MAX)));

  // Hour and pm next-state: preset, or step with 12h 11->12 pm toggle and 12->1 wrap.
  always_comb begin
    hour_d = hour_q;
    pm_d   = pm_q;
    if (do_load) begin
      hour_d = load_hour;
      pm_d   = IS12 ? load_pm : 1'b0;
    end else if (hour_inc) begin
      if (IS12) begin
        hour_d = (hour_q == TIME_W'(HOUR12_MAX)) ? TIME_W'(HOUR12_MIN) : hour_q + 1'b1;
        if (hour_q == TIME_W'(HOUR12_MAX - 1)) begin
          pm_d = ~pm_q;
        end
      end else begin
        hour_d = (hour_q == TIME_W'(HOUR24_MAX)) ? '0 : hour_q + 1'b1;
      end
    end
  end

  // Hour/pm state and registered strobes, aligned with the wrapped value.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      hour_q    <= HOUR_RST;
      pm_q      <= 1'b0;
      load_err  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
    end else begin
      hour_q    <= hour_d;
      pm_q      <= pm_d;
      load_err  <= load && !load_ok;
      min_tick  <= sec_wrap;
      hour_tick <= min_carry;
      day_tick  <= day_wrap;
    end
  end

  assign hour = hour_q;
  assign pm   = pm_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench: a 24h and a 12h instance share stimulus; values are hand-computed.
module tb_clock_time_counter;

  logic       clk_1Hz = 1'b0;
  logic       reset, run_en, load, load_pm, adj_min, adj_hour;
  logic [5:0] load_hour, load_minute, load_second;

  logic [5:0] h24, m24, s24, h12, m12, s12;
  logic       pm24, err24, mt24, ht24, dt24;
  logic       pm12, err12, mt12, ht12, dt12;

  int checks = 0;
  int errors = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  clock_time_counter #(.HOUR_MODE(24)) dut24 (
    .clk_1Hz(clk_1Hz), .reset(reset), .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
    .load_pm(load_pm), .adj_min(adj_min), .adj_hour(adj_hour),
    .hour(h24), .minute(m24), .second(s24), .pm(pm24), .load_err(err24),
    .min_tick(mt24), .hour_tick(ht24), .day_tick(dt24)
  );

  clock_time_counter #(.HOUR_MODE(12)) dut12 (
    .clk_1Hz(clk_1Hz), .reset(reset), .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
    .load_pm(load_pm), .adj_min(adj_min), .adj_hour(adj_hour),
    .hour(h12), .minute(m12), .second(s12), .pm(pm12), .load_err(err12),
    .min_tick(mt12), .hour_tick(ht12), .day_tick(dt12)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Time as hhmmss decimal for readable messages.
  function automatic int enc(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    return int'(h) * 10000 + int'(m) * 100 + int'(s);
  endfunction

  task automatic step();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic set_load(input logic en, input int h, input int m, input int s, input logic p);
    load        = en;
    load_hour   = 6'(h);
    load_minute = 6'(m);
    load_second = 6'(s);
    load_pm     = p;
  endtask

  task automatic strobes24(input string tag, input logic mt, input logic ht, input logic dt);
    check({tag, " min_tick24"}, int'(mt24), int'(mt));
    check({tag, " hour_tick24"}, int'(ht24), int'(ht));
    check({tag, " day_tick24"}, int'(dt24), int'(dt));
  endtask

  task automatic strobes12(input string tag, input logic mt, input logic ht, input logic dt);
    check({tag, " min_tick12"}, int'(mt12), int'(mt));
    check({tag, " hour_tick12"}, int'(ht12), int'(ht));
    check({tag, " day_tick12"}, int'(dt12), int'(dt));
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; adj_min = 1'b0; adj_hour = 1'b0;
    set_load(1'b0, 0, 0, 0, 1'b0);
    #2;
    check("reset time24", enc(h24, m24, s24), 0);
    check("reset time12", enc(h12, m12, s12), 120000);
    check("reset pm12", int'(pm12), 0);
    check("reset err24", int'(err24), 0);
    strobes24("reset", 1'b0, 1'b0, 1'b0);
    strobes12("reset", 1'b0, 1'b0, 1'b0);
    #1;
    reset  = 1'b0;
    run_en = 1'b1;

    // Run 61 cycles from midnight.
    for (int i = 1; i <= 61; i++) begin
      step();
      check("run min_tick24", int'(mt24), (i == 60) ? 1 : 0);
      check("run load_err24", int'(err24), 0);
    end
    check("run61 time24", enc(h24, m24, s24), 101);
    check("run61 time12", enc(h12, m12, s12), 120101);

    // 24h day rollover.
    set_load(1'b1, 23, 59, 58, 1'b0);
    step();
    check("load 235958 time24", enc(h24, m24, s24), 235958);
    check("load 235958 err24", int'(err24), 0);
    check("load 235958 err12", int'(err12), 1);
    check("load 235958 held12", enc(h12, m12, s12), 120101);
    strobes24("load", 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check("to 235959", enc(h24, m24, s24), 235959);
    check("err12 one cycle", int'(err12), 0);
    step();
    check("day wrap24", enc(h24, m24, s24), 0);
    strobes24("day wrap", 1'b1, 1'b1, 1'b1);
    step();
    check("after wrap24", enc(h24, m24, s24), 1);
    strobes24("after wrap", 1'b0, 1'b0, 1'b0);

    // 12h noon and midnight.
    set_load(1'b1, 11, 59, 59, 1'b0);
    step();
    check("load 115959 am12", enc(h12, m12, s12), 115959);
    check("load am pm12", int'(pm12), 0);
    strobes12("load am", 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    step();
    check("noon time12", enc(h12, m12, s12), 120000);
    check("noon pm12", int'(pm12), 1);
    strobes12("noon", 1'b1, 1'b1, 1'b0);
    check("noon time24", enc(h24, m24, s24), 120000);
    strobes24("noon", 1'b1, 1'b1, 1'b0);
    set_load(1'b1, 11, 59, 59, 1'b1);
    step();
    check("load pm pm12", int'(pm12), 1);
    check("load pm ignored pm24", int'(pm24), 0);
    load = 1'b0;
    step();
    check("midnight time12", enc(h12, m12, s12), 120000);
    check("midnight pm12", int'(pm12), 0);
    strobes12("midnight", 1'b1, 1'b1, 1'b1);

    // Rejected presets: hour 24 with run_en still high, then held.
    set_load(1'b1, 24, 0, 0, 1'b0);
    step();
    check("bad hour24 err24", int'(err24), 1);
    check("bad hour24 err12", int'(err12), 1);
    check("bad hour24 held24", enc(h24, m24, s24), 120000);
    check("bad hour24 held12", enc(h12, m12, s12), 120000);
    strobes24("bad load", 1'b0, 1'b0, 1'b0);
    load = 1'b0; run_en = 1'b0;
    step();
    check("err24 one cycle", int'(err24), 0);
    check("hold time24", enc(h24, m24, s24), 120000);
    set_load(1'b1, 0, 10, 0, 1'b0);
    step();
    check("hour0 err12", int'(err12), 1);
    check("hour0 held12", enc(h12, m12, s12), 120000);
    check("hour0 ok24", enc(h24, m24, s24), 1000);
    check("hour0 err24", int'(err24), 0);
    set_load(1'b1, 5, 60, 0, 1'b0);
    step();
    check("min60 err24", int'(err24), 1);
    check("min60 held24", enc(h24, m24, s24), 1000);
    set_load(1'b1, 5, 0, 60, 1'b0);
    step();
    check("sec60 err12", int'(err12), 1);
    check("sec60 held12", enc(h12, m12, s12), 120000);
    load = 1'b0;
    step();
    step();
    check("hold frozen24", enc(h24, m24, s24), 1000);
    check("hold err24", int'(err24), 0);

    // Manual adjust while halted.
    set_load(1'b1, 8, 38, 15, 1'b0);
    step();
    load = 1'b0; adj_min = 1'b1; adj_hour = 1'b1;
    step();
    check("adj both24", enc(h24, m24, s24), 93900);
    check("adj both12", enc(h12, m12, s12), 93900);
    strobes24("adj both", 1'b0, 1'b0, 1'b0);
    adj_hour = 1'b0;
    for (int i = 0; i < 59; i++) begin
      step();
      check("adj loop min_tick24", int'(mt24), 0);
      check("adj loop hour_tick24", int'(ht24), 0);
    end
    check("adj 59 wrap24", enc(h24, m24, s24), 93800);
    check("adj 59 wrap12", enc(h12, m12, s12), 93800);
    adj_min = 1'b0;

    // 12h hour adjust sequence, adjust beating count.
    set_load(1'b1, 11, 0, 5, 1'b0);
    step();
    load = 1'b0; run_en = 1'b1; adj_hour = 1'b1;
    step();
    check("adj 11->12 time12", enc(h12, m12, s12), 120005);
    check("adj 11->12 pm12", int'(pm12), 1);
    check("adj 11->12 time24", enc(h24, m24, s24), 120005);
    step();
    check("adj 12->1 time12", enc(h12, m12, s12), 10005);
    check("adj 12->1 pm12", int'(pm12), 1);
    check("adj 12->13 time24", enc(h24, m24, s24), 130005);
    adj_hour = 1'b0;
    set_load(1'b1, 23, 10, 0, 1'b0);
    step();
    load = 1'b0; adj_hour = 1'b1;
    step();
    check("adj 23->0 time24", enc(h24, m24, s24), 1000);
    strobes24("adj hour", 1'b0, 1'b0, 1'b0);
    adj_hour = 1'b0;

    // Async reset mid-cycle during a load while counting.
    set_load(1'b1, 24, 0, 0, 1'b0);
    step();
    check("pre-reset err24", int'(err24), 1);
    set_load(1'b1, 23, 59, 58, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("async reset time24", enc(h24, m24, s24), 0);
    check("async reset time12", enc(h12, m12, s12), 120000);
    check("async reset pm12", int'(pm12), 0);
    check("async reset err24", int'(err24), 0);
    strobes24("async reset", 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0; load = 1'b0;
    step();
    check("post reset time24", enc(h24, m24, s24), 1);
    check("post reset time12", enc(h12, m12, s12), 120001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
